// File: rtl/multi_ch_rx_event_tracker.sv
// -----------------------------------------------------------------------------
// multi_ch_rx_event_tracker
//   Per-channel receive-event bookkeeping for the LV2 layer-2 event builder.
//   Each channel counts one-cycle din pulses in a wrap-safe counter. Every
//   enabled channel's counter is compared against the shared readout count
//   evt_tx. need_read is raised once every enabled channel holds an unread
//   event, and need_check pulses once per readable event. Sticky per-channel
//   flags report backlog overrun and, optionally, stalled channels.
//
// Optional feature macro: RXM_TIMEOUT_EN
//   When it is defined, per-channel stall timeout counters are built.
//   When it is undefined, no timeout logic exists and ch_timeout is tied to 0.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   din         one-cycle event pulse per channel
//   ch_en       channel participates in need_read, overrun and timeout
//   evt_tx      events already read out (monotonic, wraps)
//   flag_clr    synchronous clear of sticky ch_overrun / ch_timeout
//   evt_rx      per-channel rx counters, channel i at [i*CNT_W +: CNT_W]
//   need_read   all enabled channels hold an unread event
//   need_check  one-cycle pulse: a new event is ready for readout
//   ch_overrun  sticky: backlog >= MAX_PEND
//   ch_timeout  sticky: channel stalled while other channels are pending
// -----------------------------------------------------------------------------
module multi_ch_rx_event_tracker #(
  parameter int N_CH     = 16,
  parameter int CNT_W    = 16,
  parameter int MAX_PEND = 1024,
  parameter int TMO_W    = 20,
  parameter int TMO_CYC  = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         din,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [CNT_W-1:0]        evt_tx,
  input  logic                    flag_clr,
  output logic [N_CH*CNT_W-1:0]   evt_rx,
  output logic                    need_read,
  output logic                    need_check,
  output logic [N_CH-1:0]         ch_overrun,
  output logic [N_CH-1:0]         ch_timeout
);

  // Reject configurations the wrap-safe comparison cannot represent.
  if (N_CH < 1 || N_CH > 32 || MAX_PEND >= (2 ** (CNT_W - 1)) ||
      TMO_CYC < 1 || TMO_CYC >= (2 ** TMO_W)) begin : g_bad_cfg
    $error("multi_ch_rx_event_tracker: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] MAX_PEND_C = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  logic [CNT_W-1:0] rx_q [N_CH];
  logic [CNT_W-1:0] rx_d [N_CH];
  logic [CNT_W-1:0] pend [N_CH];
  logic [CNT_W-1:0] evt_tx_q;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  ovr_set;
  logic [N_CH-1:0]  ovr_q, ovr_d;
  logic             rdy, tx_adv;
  state_t           state_q, state_d;
  logic             need_read_q;
  logic             need_check_q, need_check_d;

  // Backlog per channel; MSB set means tx is ahead, which is never pending.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pend[i]    = rx_q[i] - evt_tx;
      pending[i] = (pend[i] != {CNT_W{1'b0}}) && !pend[i][CNT_W-1];
      ovr_set[i] = ch_en[i] && !pend[i][CNT_W-1] && (pend[i] >= MAX_PEND_C);
      rx_d[i]    = rx_q[i] + {{(CNT_W-1){1'b0}}, din[i]};
    end
  end

  // Disabled channels are forced true in the AND; an empty mask is never ready.
  assign rdy    = (|ch_en) && (&(pending | ~ch_en));
  assign tx_adv = (evt_tx - evt_tx_q) == ONE_C;
  assign ovr_d  = ovr_set | (ovr_q & ~{N_CH{flag_clr}});

  // need_check sequencing: first readable event, then one pulse per tx step.
  always_comb begin
    state_d      = state_q;
    need_check_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy) begin
          need_check_d = 1'b1;
          state_d      = LOCKED;
        end else begin
          state_d      = IDLE;
        end
      end
      LOCKED: begin
        if (!rdy) begin
          state_d      = IDLE;
        end else if (tx_adv) begin
          need_check_d = 1'b1;
        end else begin
          need_check_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        need_check_d = 1'b0;
      end
    endcase
  end

  // Counters, flags, FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) rx_q[i] <= {CNT_W{1'b0}};
      evt_tx_q     <= {CNT_W{1'b0}};
      ovr_q        <= {N_CH{1'b0}};
      state_q      <= IDLE;
      need_read_q  <= 1'b0;
      need_check_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) rx_q[i] <= rx_d[i];
      evt_tx_q     <= evt_tx;
      ovr_q        <= ovr_d;
      state_q      <= state_d;
      need_read_q  <= rdy;
      need_check_q <= need_check_d;
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    evt_rx = {(N_CH*CNT_W){1'b0}};
    for (int i = 0; i < N_CH; i++) evt_rx[i*CNT_W +: CNT_W] = rx_q[i];
  end

  assign need_read  = need_read_q;
  assign need_check = need_check_q;
  assign ch_overrun = ovr_q;

`ifdef RXM_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_CYC_C  = TMO_W'(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_q [N_CH];
  logic [TMO_W-1:0] tmo_d [N_CH];
  logic [N_CH-1:0]  en_pend, tmo_run, tmo_set;
  logic [N_CH-1:0]  tmo_flag_q, tmo_flag_d;

  // A channel stalls when it is idle while some other enabled channel waits.
  always_comb begin
    en_pend = ch_en & pending;
    for (int i = 0; i < N_CH; i++) begin
      tmo_run[i] = ch_en[i] && !pending[i] &&
                   (|(en_pend & ~(N_CH'(1) << i)));
      if (tmo_run[i]) begin
        tmo_set[i] = (tmo_q[i] == TMO_LAST_C);
        tmo_d[i]   = (tmo_q[i] < TMO_CYC_C) ? tmo_q[i] + TMO_W'(1) : tmo_q[i];
      end else begin
        tmo_set[i] = 1'b0;
        tmo_d[i]   = {TMO_W{1'b0}};
      end
    end
    tmo_flag_d = tmo_set | (tmo_flag_q & ~{N_CH{flag_clr}});
  end

  // Stall counters and sticky timeout flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) tmo_q[i] <= {TMO_W{1'b0}};
      tmo_flag_q <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) tmo_q[i] <= tmo_d[i];
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign ch_timeout = tmo_flag_q;
`else
  assign ch_timeout = {N_CH{1'b0}};
`endif

endmodule

// File: tb/tb_multi_ch_rx_event_tracker.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_rx_event_tracker
//   Directed scenarios plus randomized traffic for multi_ch_rx_event_tracker.
//   The reference model keeps unbounded integer event counts and derives the
//   expected outputs with modular arithmetic. Timeout expectations follow the
//   RXM_TIMEOUT_EN macro, so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_multi_ch_rx_event_tracker;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MP = 4;
  localparam int TW = 8;
  localparam int TC = 8;
  localparam int M  = 256;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   din;
  logic [N-1:0]   ch_en;
  logic [W-1:0]   evt_tx;
  logic           flag_clr;
  logic [N*W-1:0] evt_rx;
  logic           need_read;
  logic           need_check;
  logic [N-1:0]   ch_overrun;
  logic [N-1:0]   ch_timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       rx_m [N];
  int       tc_m [N];
  int       txp_m;
  bit       nr_m, nc_m, lk_m;
  bit [N-1:0] ovr_m, tmo_m;

  multi_ch_rx_event_tracker #(
    .N_CH(N), .CNT_W(W), .MAX_PEND(MP), .TMO_W(TW), .TMO_CYC(TC)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .ch_en(ch_en), .evt_tx(evt_tx),
    .flag_clr(flag_clr), .evt_rx(evt_rx), .need_read(need_read),
    .need_check(need_check), .ch_overrun(ch_overrun), .ch_timeout(ch_timeout)
  );

  always #5 clk = ~clk;

  function automatic int modm(input int v);
    return ((v % M) + M) % M;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      rx_m[i] = 0;
      tc_m[i] = 0;
    end
    txp_m = 0; nr_m = 0; nc_m = 0; lk_m = 0; ovr_m = '0; tmo_m = '0;
  endtask

  // Advance DUT and model by one clock with the currently driven inputs.
  task automatic step();
    int p [N];
    bit pnd [N];
    bit rdy, adv, nnc, others, run;
    bit [N-1:0] novr, ntmo;
    int nrx [N];
    int ntc [N];
    int tx_now;
    tx_now = int'(evt_tx);
    for (int i = 0; i < N; i++) begin
      p[i]   = modm(rx_m[i] - tx_now);
      pnd[i] = (p[i] != 0) && (p[i] < M / 2);
    end
    rdy = (ch_en != '0);
    for (int i = 0; i < N; i++) if (ch_en[i] && !pnd[i]) rdy = 0;
    adv = (modm(tx_now - txp_m) == 1);
    nnc = rdy && (!lk_m || adv);
    for (int i = 0; i < N; i++) begin
      novr[i] = (ch_en[i] && p[i] < M / 2 && p[i] >= MP) || (ovr_m[i] && !flag_clr);
      nrx[i]  = modm(rx_m[i] + int'(din[i]));
      ntc[i]  = 0;
      ntmo[i] = 1'b0;
`ifdef RXM_TIMEOUT_EN
      others = 0;
      for (int j = 0; j < N; j++) if (j != i && ch_en[j] && pnd[j]) others = 1;
      run = ch_en[i] && !pnd[i] && others;
      ntc[i]  = run ? ((tc_m[i] < TC) ? tc_m[i] + 1 : tc_m[i]) : 0;
      ntmo[i] = (run && tc_m[i] == TC - 1) || (tmo_m[i] && !flag_clr);
`endif
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      rx_m[i] = nrx[i];
      tc_m[i] = ntc[i];
    end
    txp_m = tx_now; lk_m = rdy; nr_m = rdy; nc_m = nnc; ovr_m = novr; tmo_m = ntmo;
  endtask

  task automatic do_reset();
    din = '0; ch_en = '0; evt_tx = '0; flag_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    din = '0; ch_en = '0; evt_tx = '0; flag_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({evt_rx, need_read, need_check, ch_overrun, ch_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_state: got rx=%h nr=%b nc=%b ovr=%b tmo=%b, want all 0",
               evt_rx, need_read, need_check, ch_overrun, ch_timeout);
    end
    reset = 1'b0;
    model_reset();
    step();
    checks++;
    if ({evt_rx, need_read, need_check} !== '0) begin
      errors++;
      $display("FAIL reset_release: got rx=%h nr=%b nc=%b, want 0", evt_rx, need_read, need_check);
    end
  endtask

  // Two channels fill, then readout steps produce one pulse each.
  task automatic test_basic();
    int pulses;
    do_reset();
    ch_en = 4'b0011;
    din = 4'b0001; step();
    din = 4'b0010; step();
    din = 4'b0000; step();
    checks++;
    if (need_read !== 1'b1 || need_check !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got nr=%b nc=%b, want 1 1", need_read, need_check);
    end
    checks++;
    if (evt_rx[W-1:0] !== 8'd1 || evt_rx[2*W-1:W] !== 8'd1) begin
      errors++;
      $display("FAIL basic_counts: got ch0=%0d ch1=%0d, want 1 1", evt_rx[W-1:0], evt_rx[2*W-1:W]);
    end
    step();
    checks++;
    if (need_check !== 1'b0 || need_read !== 1'b1) begin
      errors++;
      $display("FAIL basic_single_pulse: got nc=%b nr=%b, want 0 1", need_check, need_read);
    end
    evt_tx = 8'd1; step();
    checks++;
    if (need_read !== 1'b0 || need_check !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got nr=%b nc=%b, want 0 0", need_read, need_check);
    end
    pulses = 0;
    din = 4'b0011;
    repeat (3) begin step(); pulses += int'(need_check); end
    din = 4'b0000; step(); pulses += int'(need_check);
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL refill_pulses: got %0d, want 1", pulses);
    end
    for (int t = 2; t <= 3; t++) begin
      evt_tx = W'(t); step();
      checks++;
      if (need_check !== 1'b1 || need_read !== 1'b1) begin
        errors++;
        $display("FAIL tx_step_pulse: tx=%0d got nc=%b nr=%b, want 1 1", t, need_check, need_read);
      end
    end
    step();
    checks++;
    if (need_check !== 1'b0) begin
      errors++;
      $display("FAIL tx_hold_no_pulse: got nc=%b, want 0", need_check);
    end
  endtask

  // Enable mask: disabled channels are ignored, empty mask is never ready.
  task automatic test_enable();
    do_reset();
    ch_en = 4'b0001;
    din = 4'b0001; step();
    din = 4'b0000; step();
    checks++;
    if (need_read !== 1'b1) begin
      errors++;
      $display("FAIL enable_ch0_only: got nr=%b, want 1", need_read);
    end
    ch_en = 4'b0011; step();
    checks++;
    if (need_read !== 1'b0) begin
      errors++;
      $display("FAIL enable_add_ch1: got nr=%b, want 0", need_read);
    end
    ch_en = 4'b0000; step();
    checks++;
    if (need_read !== 1'b0) begin
      errors++;
      $display("FAIL enable_empty_mask: got nr=%b, want 0", need_read);
    end
  endtask

  // Counter wrap and wrap-safe pending decision.
  task automatic test_wrap();
    do_reset();
    ch_en = 4'b0001;
    din = 4'b0001;
    repeat (M + 1) step();
    din = 4'b0000; step();
    checks++;
    if (evt_rx[W-1:0] !== 8'h01) begin
      errors++;
      $display("FAIL wrap_count: got %h, want 01", evt_rx[W-1:0]);
    end
    evt_tx = 8'hFF; step(); step();
    checks++;
    if (need_read !== 1'b1) begin
      errors++;
      $display("FAIL wrap_pending: got nr=%b, want 1", need_read);
    end
    evt_tx = 8'h01; step();
    checks++;
    if (need_read !== 1'b0) begin
      errors++;
      $display("FAIL wrap_not_pending: got nr=%b, want 0", need_read);
    end
  endtask

  // Overrun threshold, stickiness, clear, and set-wins-over-clear.
  task automatic test_overrun();
    do_reset();
    ch_en = 4'b0001;
    din = 4'b0001;
    repeat (4) step();
    checks++;
    if (ch_overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_below: got %b, want 0000", ch_overrun);
    end
    din = 4'b0000; step();
    checks++;
    if (ch_overrun !== 4'b0001) begin
      errors++;
      $display("FAIL ovr_at_max: got %b, want 0001", ch_overrun);
    end
    evt_tx = 8'd4; step(); step();
    checks++;
    if (ch_overrun !== 4'b0001) begin
      errors++;
      $display("FAIL ovr_sticky: got %b, want 0001", ch_overrun);
    end
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    checks++;
    if (ch_overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_clear: got %b, want 0000", ch_overrun);
    end
    din = 4'b0001;
    repeat (4) step();
    din = 4'b0000; step();
    flag_clr = 1'b1; step(); flag_clr = 1'b0;
    checks++;
    if (ch_overrun !== 4'b0001) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b, want 0001", ch_overrun);
    end
  endtask

  // Stalled-channel timeout, then an asynchronous reset mid-cycle.
  task automatic test_timeout();
    bit [N-1:0] exp_tmo;
    do_reset();
    ch_en = 4'b0011;
    din = 4'b0001; step();
    din = 4'b0000;
    repeat (TC - 1) step();
    checks++;
    if (ch_timeout !== 4'b0000) begin
      errors++;
      $display("FAIL tmo_early: got %b, want 0000", ch_timeout);
    end
    step();
`ifdef RXM_TIMEOUT_EN
    exp_tmo = 4'b0010;
`else
    exp_tmo = 4'b0000;
`endif
    checks++;
    if (ch_timeout !== exp_tmo) begin
      errors++;
      $display("FAIL tmo_expire: got %b, want %b", ch_timeout, exp_tmo);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({evt_rx, need_read, need_check, ch_overrun, ch_timeout} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rx=%h nr=%b nc=%b ovr=%b tmo=%b, want all 0",
               evt_rx, need_read, need_check, ch_overrun, ch_timeout);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Random traffic compared cycle by cycle against the model.
  task automatic test_random();
    logic [N*W-1:0] exp_rx;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      din      = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      ch_en    = ($urandom_range(0, 9) < 8) ? 4'hF : N'($urandom_range(0, 15));
      flag_clr = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 39))
        0, 1:    evt_tx = evt_tx + W'($urandom_range(2, 5));
        default: if ($urandom_range(0, 3) == 0) evt_tx = evt_tx + 8'd1;
      endcase
      step();
      for (int i = 0; i < N; i++) exp_rx[i*W +: W] = W'(rx_m[i]);
      checks++;
      if (evt_rx !== exp_rx) begin
        errors++;
        $display("FAIL rnd_evt_rx: cyc %0d got %h, want %h", c, evt_rx, exp_rx);
      end
      checks++;
      if (need_read !== nr_m || need_check !== nc_m) begin
        errors++;
        $display("FAIL rnd_need: cyc %0d got nr=%b nc=%b, want %b %b", c, need_read, need_check, nr_m, nc_m);
      end
      checks++;
      if (ch_overrun !== ovr_m || ch_timeout !== tmo_m) begin
        errors++;
        $display("FAIL rnd_flags: cyc %0d got ovr=%b tmo=%b, want %b %b", c, ch_overrun, ch_timeout, ovr_m, tmo_m);
      end
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; ch_en = '0; evt_tx = '0; flag_clr = 1'b0;
    test_reset();
    test_basic();
    test_enable();
    test_wrap();
    test_overrun();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
